// File: rtl/shiftreg_pkg.sv
// ----------------------------------------------------------------------------
// shiftreg_pkg
//
// Shared types for the universal shift register.
//   op_t    : operation code presented on the op port
//   state_t : control FSM states
//   is_shift: true for the two shifting operations
// ----------------------------------------------------------------------------
package shiftreg_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_SHR  = 2'b10,
    OP_SHL  = 2'b11
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic is_shift(input op_t op);
    return (op == OP_SHR) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/shiftreg_step_ctr.sv
// ----------------------------------------------------------------------------
// shiftreg_step_ctr
//
// Down-counter of shift steps still to be performed after the current edge.
//
// Ports:
//   clk       in  1   clock, rising edge
//   reset     in  1   synchronous active-high reset, clears the counter
//   load      in  1   load load_val (takes priority over decrement)
//   load_val  in  CW  value to load
//   decrement in  1   count down by one (saturates at zero)
//   last      out 1   exactly one step remains
// ----------------------------------------------------------------------------
module shiftreg_step_ctr #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          decrement,
  output logic          last
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (decrement && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/univ_shift_register.sv
// ----------------------------------------------------------------------------
// univ_shift_register
//
// Universal shift register with valid/ready operation handshake. An accepted
// SHR/SHL of N steps shifts once on the accepting edge and once per edge
// afterwards; done pulses for one cycle after the final step (or after an
// accepted HOLD/LOAD/zero-count shift).
//
// Optional feature: define SHIFTREG_ROTATE_EN to add the rotate input. When
// rotate is high at acceptance, every shift of that operation feeds the bit
// leaving the register back in at the other end instead of ser_in.
//
// Ports:
//   clk        in  1      clock, rising edge
//   reset      in  1      synchronous active-high reset
//   op         in  2      00 HOLD, 01 LOAD, 10 SHR (toward bit 0), 11 SHL
//   op_valid   in  1      operation request
//   op_ready   out 1      high while idle (operation can be accepted)
//   count      in  CW     number of shift steps
//   load_data  in  WIDTH  parallel load value
//   ser_in     in  1      serial input (MSB on SHR, LSB on SHL)
//   rotate     in  1      rotate instead of serial input (SHIFTREG_ROTATE_EN)
//   q          out WIDTH  register contents
//   ser_out    out 1      bit shifted out on the most recent shift edge
//   done       out 1      one-cycle completion pulse
// ----------------------------------------------------------------------------
module univ_shift_register
  import shiftreg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [CW-1:0]    count,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
`ifdef SHIFTREG_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             done
);

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  state_t state_q;
  logic   shl_q;     // direction of the operation in flight
  logic   done_q;
`ifdef SHIFTREG_ROTATE_EN
  logic   rot_q;     // rotate mode of the operation in flight
`endif

  // --------------------------------------------------------------------------
  // Acceptance decode
  // --------------------------------------------------------------------------
  op_t  op_in;
  logic accept;
  logic acc_shift;   // accepted shift that moves at least one step
  logic busy_shift;
  logic shift_en;
  logic load_en;
  logic ctr_load;    // operation needs more than the accepting edge
  logic last;

  assign op_in      = op_t'(op);
  assign op_ready   = (state_q == ST_IDLE);
  assign accept     = op_valid && op_ready;
  assign acc_shift  = accept && is_shift(op_in) && (count != '0);
  assign busy_shift = (state_q == ST_BUSY);
  assign shift_en   = acc_shift || busy_shift;
  assign load_en    = accept && (op_in == OP_LOAD);
  assign ctr_load   = acc_shift && (count > CW'(1));

  // --------------------------------------------------------------------------
  // Shift datapath (combinational next value)
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] q_q;
  logic             ser_out_q;
  logic             shift_left;
  logic             rot_now;
  logic             out_bit;
  logic             in_bit;
  logic [WIDTH-1:0] shifted;

  // On the accepting edge direction/rotate come straight from the inputs;
  // afterwards from the values latched at acceptance.
  assign shift_left = acc_shift ? (op_in == OP_SHL) : shl_q;

`ifdef SHIFTREG_ROTATE_EN
  assign rot_now = acc_shift ? rotate : rot_q;
`else
  assign rot_now = 1'b0;
`endif

  assign out_bit = shift_left ? q_q[WIDTH-1] : q_q[0];
  assign in_bit  = rot_now ? out_bit : ser_in;
  assign shifted = shift_left ? {q_q[WIDTH-2:0], in_bit} : {in_bit, q_q[WIDTH-1:1]};

  // --------------------------------------------------------------------------
  // Remaining-step counter: holds steps left after the current edge
  // --------------------------------------------------------------------------
  shiftreg_step_ctr #(
    .CW (CW)
  ) u_step_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (ctr_load),
    .load_val  (count - CW'(1)),
    .decrement (busy_shift),
    .last      (last)
  );

  // --------------------------------------------------------------------------
  // Control FSM with registered done
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shl_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFTREG_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shl_q <= (op_in == OP_SHL);
`ifdef SHIFTREG_ROTATE_EN
            rot_q <= rotate;
`endif
            if (ctr_load) begin
              state_q <= ST_BUSY;
            end else begin
              // HOLD, LOAD, zero-count and single-step shifts finish here
              done_q <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          // op_valid, op and count are ignored while busy
          if (last) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // q datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q       <= '0;
      ser_out_q <= 1'b0;
    end else if (load_en) begin
      q_q <= load_data;
    end else if (shift_en) begin
      q_q       <= shifted;
      ser_out_q <= out_bit;
    end
  end

  assign q       = q_q;
  assign ser_out = ser_out_q;
  assign done    = done_q;

endmodule
